// File: rtl/pll_sched_pkg.sv
// Shared types and constants for the PLL reconfiguration scheduler.
package pll_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StStart,
    StWaitDone,
    StWaitLock,
    StResp
  } state_e;

  // Config slice widths: 8-bit M and N, five 8-bit output dividers.
  localparam int unsigned MultW  = 8;
  localparam int unsigned DivW   = 8;
  localparam int unsigned CdivN  = 5;
  localparam int unsigned CdivW  = 8 * CdivN;

  // Default timeouts in clock cycles.
  localparam int unsigned DefDoneTimeout = 4095;
  localparam int unsigned DefLockTimeout = 65535;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from one past the last grant.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);

  logic          found;
  logic [PW-1:0] cand;

  // Walk positions ptr+1 .. ptr+NREQ (mod NREQ) and take the first request.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = PW'((32'(ptr_i) + off) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/pll_reconf_sched.sv
// Shares one PLL reconfiguration port between NREQ requesters: arbitrates,
// latches the winner's config, starts one scan, waits for scan-done and lock.
module pll_reconf_sched
  import pll_sched_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DONE_TIMEOUT = DefDoneTimeout,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [MultW*NREQ-1:0]   req_mult,
  input  logic [DivW*NREQ-1:0]    req_div,
  input  logic [CdivW*NREQ-1:0]   req_cdiv,
  output logic [NREQ-1:0]         grant,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  output logic [MultW-1:0]        Mult,
  output logic [DivW-1:0]         div,
  output logic [CdivW-1:0]        clk_div,
  output logic                    update_req,
  input  logic                    scan_done,
  input  logic                    pll_locked
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] DoneTo = CW'(DONE_TIMEOUT);
  localparam logic [CW-1:0] LockTo = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CntMax = '1;

  state_e            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [PW-1:0]     idx_q;
  logic [PW-1:0]     ptr_q;
  logic              done_q, err_q, busy_q, update_q;
  logic [MultW-1:0]  mult_q;
  logic [DivW-1:0]   div_q;
  logic [CdivW-1:0]  cdiv_q;
  logic [CW-1:0]     cnt_q;
  logic              scan_prev_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic [MultW-1:0]  sel_mult;
  logic [DivW-1:0]   sel_div;
  logic [CdivW-1:0]  sel_cdiv;
  logic              scan_rise;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Select the arbitration winner's config slices.
  always_comb begin
    sel_mult = '0;
    sel_div  = '0;
    sel_cdiv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PW'(i)) begin
        sel_mult = req_mult[i*MultW +: MultW];
        sel_div  = req_div[i*DivW +: DivW];
        sel_cdiv = req_cdiv[i*CdivW +: CdivW];
      end
    end
  end

  assign scan_rise = scan_done & ~scan_prev_q;

  // Scheduler FSM with registered outputs, timeout counter and edge detect.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      idx_q       <= '0;
      ptr_q       <= PW'(NREQ - 1);
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      update_q    <= 1'b0;
      mult_q      <= '0;
      div_q       <= '0;
      cdiv_q      <= '0;
      cnt_q       <= '0;
      // High so a scan_done level already present is not taken as an edge.
      scan_prev_q <= 1'b1;
    end else begin
      scan_prev_q <= scan_done;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      update_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q <= StLatch;
            grant_q <= arb_gnt;
            idx_q   <= arb_idx;
            mult_q  <= sel_mult;
            div_q   <= sel_div;
            cdiv_q  <= sel_cdiv;
            busy_q  <= 1'b1;
          end
        end
        StLatch: begin
          state_q  <= StStart;
          update_q <= 1'b1;
        end
        StStart: begin
          cnt_q   <= '0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (scan_rise) begin
            cnt_q   <= '0;
            state_q <= StWaitLock;
          end else if (cnt_q == DoneTo) begin
            err_q   <= 1'b1;
            state_q <= StResp;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (pll_locked) begin
            done_q  <= 1'b1;
            state_q <= StResp;
          end else if (cnt_q == LockTo) begin
            err_q   <= 1'b1;
            state_q <= StResp;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          ptr_q   <= idx_q;
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign update_req = update_q;
  assign Mult       = mult_q;
  assign div        = div_q;
  assign clk_div    = cdiv_q;

endmodule

// File: tb/tb_pll_reconf_sched.sv
// Directed bench for pll_reconf_sched with hand-derived expected values.
module tb_pll_reconf_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DT   = 30;
  localparam int unsigned LT   = 40;

  logic              clock = 1'b0;
  logic              rst   = 1'b1;
  logic [NREQ-1:0]   req   = '0;
  logic [8*NREQ-1:0] req_mult;
  logic [8*NREQ-1:0] req_div;
  logic [40*NREQ-1:0] req_cdiv;
  logic [NREQ-1:0]   grant;
  logic              done, err, busy, update_req;
  logic [7:0]        Mult, div;
  logic [39:0]       clk_div;
  logic              scan_done  = 1'b0;
  logic              pll_locked = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  pll_reconf_sched #(
    .NREQ         (NREQ),
    .DONE_TIMEOUT (DT),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .req        (req),
    .req_mult   (req_mult),
    .req_div    (req_div),
    .req_cdiv   (req_cdiv),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .Mult       (Mult),
    .div        (div),
    .clk_div    (clk_div),
    .update_req (update_req),
    .scan_done  (scan_done),
    .pll_locked (pll_locked)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clock) begin
    if (update_req) upd_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] exp_mult(input int i);
    return 8'(16 + i);
  endfunction

  function automatic logic [7:0] exp_div(input int i);
    return 8'(2 + i);
  endfunction

  function automatic logic [39:0] exp_cdiv(input int i);
    logic [39:0] v;
    for (int k = 0; k < 5; k++) v[k*8 +: 8] = 8'(4 + 16 * k + i);
    return v;
  endfunction

  task automatic load_cfg();
    for (int i = 0; i < NREQ; i++) begin
      req_mult[i*8 +: 8]  = exp_mult(i);
      req_div[i*8 +: 8]   = exp_div(i);
      req_cdiv[i*40 +: 40] = exp_cdiv(i);
    end
  endtask

  // One full operation. dly_scan < 0: no scan edge; dly_lock < 0: no lock.
  task automatic run_op(input string tag, input int dly_scan, input int dly_lock,
                        input logic [NREQ-1:0] exp_gnt, input logic exp_ok,
                        input bit drop, input bit mutate);
    int   base;
    int   n;
    int   idx;
    int   exp_n;
    logic got;
    base = upd_cnt;
    idx  = 0;
    for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) idx = i;
    got = 1'b0;
    for (n = 0; n < 10 && !got; n++) begin
      step();
      got = update_req;
    end
    check_eq({tag, "_upd_seen"}, 64'(got), 64'd1);
    check_eq({tag, "_upd_lat"}, 64'(n), 64'd2);
    check_eq({tag, "_grant"}, 64'(grant), 64'(exp_gnt));
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_mult"}, 64'(Mult), 64'(exp_mult(idx)));
    check_eq({tag, "_div"}, 64'(div), 64'(exp_div(idx)));
    check_eq({tag, "_cdiv"}, 64'(clk_div), 64'(exp_cdiv(idx)));
    if (dly_scan >= 0) begin
      for (int i = 0; i < dly_scan; i++) begin
        step();
        if (mutate && i == 0) begin
          req_mult[idx*8 +: 8] = 8'hEE;
          req = req & ~exp_gnt;
        end
      end
      scan_done = 1'b1;
      if (dly_lock >= 0) begin
        repeat (dly_lock) step();
        pll_locked = 1'b1;
      end
    end
    exp_n = (dly_scan < 0) ? int'(DT + 2) : (dly_lock < 0) ? int'(LT + 2) : 1;
    got = 1'b0;
    for (n = 0; n < int'(DT + LT + 50) && !got; n++) begin
      step();
      got = done | err;
    end
    check_eq({tag, "_resp_seen"}, 64'(got), 64'd1);
    check_eq({tag, "_resp_lat"}, 64'(n), 64'(exp_n));
    check_eq({tag, "_done"}, 64'(done), 64'(exp_ok));
    check_eq({tag, "_err"}, 64'(err), 64'(!exp_ok));
    check_eq({tag, "_resp_grant"}, 64'(grant), 64'(exp_gnt));
    if (mutate) check_eq({tag, "_mult_held"}, 64'(Mult), 64'(exp_mult(idx)));
    if (drop) req = req & ~exp_gnt;
    if (mutate) req_mult[idx*8 +: 8] = exp_mult(idx);
    step();
    check_eq({tag, "_done_clr"}, 64'(done), 64'd0);
    check_eq({tag, "_err_clr"}, 64'(err), 64'd0);
    check_eq({tag, "_grant_clr"}, 64'(grant), 64'd0);
    check_eq({tag, "_busy_clr"}, 64'(busy), 64'd0);
    check_eq({tag, "_upd_once"}, 64'(upd_cnt - base), 64'd1);
    scan_done  = 1'b0;
    pll_locked = 1'b0;
  endtask

  initial begin
    int d0;
    int e0;
    load_cfg();
    step();
    step();
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_upd", 64'(update_req), 64'd0);
    check_eq("rst_mult", 64'(Mult), 64'd0);
    check_eq("rst_div", 64'(div), 64'd0);
    check_eq("rst_cdiv", 64'(clk_div), 64'd0);
    rst = 1'b0;

    // Single request with the example timing.
    req = 4'b0001;
    run_op("single", 20, 10, 4'b0001, 1'b1, 1'b1, 1'b0);

    // Fairness from reset: index 0 first, then rotate.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    run_op("fair0", 5, 3, 4'b0001, 1'b1, 1'b0, 1'b0);
    run_op("fair1", 5, 3, 4'b0010, 1'b1, 1'b0, 1'b0);
    run_op("fair2", 5, 3, 4'b0100, 1'b1, 1'b0, 1'b0);
    run_op("fair3", 5, 3, 4'b1000, 1'b1, 1'b0, 1'b0);
    run_op("fair4", 5, 3, 4'b0001, 1'b1, 1'b0, 1'b0);
    req = '0;

    // Scan-done timeout, then the next requester is served.
    req = 4'b0110;
    run_op("dto", -1, -1, 4'b0010, 1'b0, 1'b1, 1'b0);
    run_op("dto_next", 20, 5, 4'b0100, 1'b1, 1'b1, 1'b0);

    // Lock timeout.
    req = 4'b0001;
    run_op("lto", 10, -1, 4'b0001, 1'b0, 1'b1, 1'b0);

    // Winner changes its config and drops req mid-scan.
    req = 4'b0100;
    run_op("iso", 15, 5, 4'b0100, 1'b1, 1'b1, 1'b1);

    // Reset while waiting for lock.
    req = 4'b1000;
    step();
    step();
    check_eq("mid_upd", 64'(update_req), 64'd1);
    check_eq("mid_grant", 64'(grant), 64'(4'b1000));
    repeat (3) step();
    scan_done = 1'b1;
    step();
    step();
    d0 = done_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    step();
    check_eq("mid_rst_grant", 64'(grant), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    check_eq("mid_rst_err", 64'(err), 64'd0);
    check_eq("mid_rst_mult", 64'(Mult), 64'd0);
    check_eq("mid_rst_cdiv", 64'(clk_div), 64'd0);
    rst = 1'b0;
    req = '0;
    repeat (3) step();
    check_eq("mid_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("mid_no_err", 64'(err_cnt - e0), 64'd0);

    // scan_done still high: no edge, so the operation must time out.
    req = 4'b0001;
    run_op("post_rst", -1, -1, 4'b0001, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
